// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: the operation encoding, the
// positions of the flag bits inside the flag vector, and small helpers for
// building flag vectors and classifying opcodes.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Operation encoding. Code 4'd15 is left unassigned and executes as CPY.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_CMP = 4'd4,
        OP_AND = 4'd5,
        OP_ORR = 4'd6,
        OP_XOR = 4'd7,
        OP_LSL = 4'd8,
        OP_LSR = 4'd9,
        OP_ASR = 4'd10,
        OP_ROL = 4'd11,
        OP_ROR = 4'd12,
        OP_CPY = 4'd13,
        OP_MUL = 4'd14
    } oper_e;

    // Flag vector layout is {V,N,C,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    // Assemble a flag vector from its individual bits.
    function automatic logic [FLAG_W-1:0] pack_flags(input logic v,
                                                     input logic n,
                                                     input logic c,
                                                     input logic z);
        return {v, n, c, z};
    endfunction

    // True for the five shift/rotate opcodes.
    function automatic logic is_shift_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core
// Purely combinational datapath of the sequential ALU.
//   Single-cycle path : i_op, i_a, i_b, i_flags -> o_res, o_flags
//                       (add/sub family, compare, logic ops, copy, and the
//                       zero-count shift/rotate pass-through)
//   Shift step path   : i_step_op, i_step_val   -> o_step_val, o_step_c
//                       (moves the value by exactly one bit position and
//                       reports the bit that crossed the word boundary)
// -----------------------------------------------------------------------------
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]        i_op,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [FLAG_W-1:0] i_flags,
    output logic [WIDTH-1:0]  o_res,
    output logic [FLAG_W-1:0] o_flags,
    input  logic [3:0]        i_step_op,
    input  logic [WIDTH-1:0]  i_step_val,
    output logic [WIDTH-1:0]  o_step_val,
    output logic              o_step_c
);

    logic [WIDTH-1:0] w_bop;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_pass;

    // Operand conditioning: subtraction is a + ~b + carry-in.
    always_comb begin
        w_bop = i_b;
        w_cin = 1'b0;
        case (i_op)
            OP_ADC: begin
                w_bop = i_b;
                w_cin = i_flags[FLAG_C];
            end
            OP_SUB, OP_CMP: begin
                w_bop = ~i_b;
                w_cin = 1'b1;
            end
            OP_SBC: begin
                w_bop = ~i_b;
                w_cin = i_flags[FLAG_C];
            end
            default: begin
                w_bop = i_b;
                w_cin = 1'b0;
            end
        endcase
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
    // Signed overflow: operands agree in sign but the result does not.
    assign w_ovf = (i_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    // Result selection; C and V default to the incoming flags.
    always_comb begin
        w_res  = i_a;
        w_c    = i_flags[FLAG_C];
        w_v    = i_flags[FLAG_V];
        w_pass = 1'b0;
        case (i_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_ovf;
            end
            OP_AND: w_res = i_a & i_b;
            OP_ORR: w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            // Only reaches here with a zero count: value and flags pass through.
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: w_pass = 1'b1;
            // CPY and unassigned codes copy a.
            default: w_res = i_a;
        endcase
    end

    // Flag generation: N and Z always follow the computed value.
    always_comb begin
        o_res = w_res;
        if (w_pass) begin
            o_flags = i_flags;
        end else begin
            o_flags = pack_flags(w_v, w_res[WIDTH-1], w_c, (w_res == {WIDTH{1'b0}}));
        end
    end

    // One-bit shift/rotate step.
    always_comb begin
        o_step_val = i_step_val;
        o_step_c   = 1'b0;
        case (i_step_op)
            OP_LSL: begin
                o_step_val = {i_step_val[WIDTH-2:0], 1'b0};
                o_step_c   = i_step_val[WIDTH-1];
            end
            OP_LSR: begin
                o_step_val = {1'b0, i_step_val[WIDTH-1:1]};
                o_step_c   = i_step_val[0];
            end
            OP_ASR: begin
                o_step_val = {i_step_val[WIDTH-1], i_step_val[WIDTH-1:1]};
                o_step_c   = i_step_val[0];
            end
            OP_ROL: begin
                o_step_val = {i_step_val[WIDTH-2:0], i_step_val[WIDTH-1]};
                o_step_c   = i_step_val[WIDTH-1];
            end
            OP_ROR: begin
                o_step_val = {i_step_val[0], i_step_val[WIDTH-1:1]};
                o_step_c   = i_step_val[0];
            end
            default: begin
                o_step_val = i_step_val;
                o_step_c   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential ALU. Most operations complete on the accepting edge; shifts and
// rotates with a non-zero count walk one bit per cycle, and MUL runs a
// WIDTH-cycle unsigned shift-add.
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high
//   start          : request an operation (taken only while busy=0)
//   oper           : opcode (alu_pkg::oper_e)
//   a_in, b_in     : operands
//   proc_flags_in  : incoming flags {V,N,C,Z}
//   busy           : multi-cycle operation in progress
//   done           : one-cycle pulse when out/proc_flags_out update
//   out            : registered result
//   proc_flags_out : registered flags {V,N,C,Z}
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        oper,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [FLAG_W-1:0] proc_flags_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  out,
    output logic [FLAG_W-1:0] proc_flags_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_MUL   = 2'd2;

    localparam int               LOG_W  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_DATA = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] W_CNT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_0  = CNT_W'(0);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_op;
    logic              r_v;
    logic [WIDTH-1:0]  r_lo;      // shift value, or multiplier/low product half
    logic [WIDTH-1:0]  r_hi;      // high product half
    logic [WIDTH-1:0]  r_mcand;   // multiplicand
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_out;
    logic [FLAG_W-1:0] r_flags;

    logic [CNT_W-1:0]  w_shift_n;
    logic [WIDTH-1:0]  w_core_res;
    logic [FLAG_W-1:0] w_core_flags;
    logic [WIDTH-1:0]  w_step_val;
    logic              w_step_c;
    logic [WIDTH:0]    w_mul_sum;
    logic [WIDTH-1:0]  w_mul_hi;
    logic [WIDTH-1:0]  w_mul_lo;
    logic              w_last;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .i_op       (oper),
        .i_a        (a_in),
        .i_b        (b_in),
        .i_flags    (proc_flags_in),
        .o_res      (w_core_res),
        .o_flags    (w_core_flags),
        .i_step_op  (r_op),
        .i_step_val (r_lo),
        .o_step_val (w_step_val),
        .o_step_c   (w_step_c)
    );

    // Shift count: linear shifts saturate at WIDTH, rotates wrap modulo WIDTH.
    always_comb begin
        w_shift_n = CNT_0;
        case (oper)
            OP_LSL, OP_LSR, OP_ASR: begin
                if (b_in >= W_DATA) begin
                    w_shift_n = W_CNT;
                end else begin
                    w_shift_n = CNT_W'(b_in);
                end
            end
            OP_ROL, OP_ROR: w_shift_n = CNT_W'(b_in[LOG_W-1:0]);
            default:        w_shift_n = CNT_0;
        endcase
    end

    // Shift-add step: conditionally add the multiplicand to the high half,
    // then shift the whole {carry, hi, lo} product right by one.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    assign w_last    = (r_cnt == CNT_1);

    // Control FSM, step counter and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_0;
            r_op    <= 4'd0;
            r_v     <= 1'b0;
            r_lo    <= {WIDTH{1'b0}};
            r_hi    <= {WIDTH{1'b0}};
            r_mcand <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= {WIDTH{1'b0}};
            r_flags <= {FLAG_W{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= oper;
                        r_v  <= proc_flags_in[FLAG_V];
                        if (oper == OP_MUL) begin
                            r_state <= ST_MUL;
                            r_busy  <= 1'b1;
                            r_cnt   <= W_CNT;
                            r_hi    <= {WIDTH{1'b0}};
                            r_lo    <= b_in;
                            r_mcand <= a_in;
                        end else if (is_shift_op(oper) && (w_shift_n != CNT_0)) begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                            r_cnt   <= w_shift_n;
                            r_lo    <= a_in;
                        end else begin
                            r_done  <= 1'b1;
                            r_flags <= w_core_flags;
                            // CMP only updates flags; the difference is discarded.
                            if (oper != OP_CMP) begin
                                r_out <= w_core_res;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    r_lo  <= w_step_val;
                    r_cnt <= r_cnt - CNT_1;
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= w_step_val;
                        r_flags <= pack_flags(r_v, w_step_val[WIDTH-1], w_step_c,
                                              (w_step_val == {WIDTH{1'b0}}));
                    end
                end
                ST_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt - CNT_1;
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= w_mul_lo;
                        r_flags <= pack_flags(r_v, w_mul_lo[WIDTH-1], (|w_mul_hi),
                                              (w_mul_lo == {WIDTH{1'b0}}));
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign out            = r_out;
    assign proc_flags_out = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Scoreboard bench for alu_seq (WIDTH=16): the expected result of each
// accepted operation is computed by a behavioural model and queued; it is
// popped and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  oper = 4'd0;
    logic [15:0] a_in = 16'd0;
    logic [15:0] b_in = 16'd0;
    logic [3:0]  proc_flags_in = 4'd0;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic [3:0]  proc_flags_out;

    alu_seq #(.WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .oper           (oper),
        .a_in           (a_in),
        .b_in           (b_in),
        .proc_flags_in  (proc_flags_in),
        .busy           (busy),
        .done           (done),
        .out            (out),
        .proc_flags_out (proc_flags_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [15:0] out;
        logic [3:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_out = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: whole-word arithmetic, shifts and multiply.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] f,
                                   input logic [15:0] prev);
        exp_t        e;
        logic [16:0] s;
        logic [15:0] bb;
        logic [15:0] r;
        logic [31:0] x;
        logic        cin;
        logic        c;
        logic        v;
        int          si;
        int          n;
        e.out = prev; e.flags = f; e.lat = 0; e.acc = 0;
        r = a; c = f[1]; v = f[3]; n = 0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                bb  = (op == OP_ADD || op == OP_ADC) ? b : ~b;
                cin = (op == OP_ADD) ? 1'b0 : ((op == OP_SUB || op == OP_CMP) ? 1'b1 : f[1]);
                s   = {1'b0, a} + {1'b0, bb} + {16'd0, cin};
                si  = int'($signed(a)) + int'($signed(bb)) + (cin ? 1 : 0);
                r   = s[15:0];
                c   = s[16];
                v   = (si > 32767) || (si < -32768);
            end
            OP_AND: r = a & b;
            OP_ORR: r = a | b;
            OP_XOR: r = a ^ b;
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
                if (op == OP_ROL || op == OP_ROR) n = int'(b) % 16;
                else                              n = (b > 16'd16) ? 16 : int'(b);
                if (n == 0) begin
                    e.out = a;
                    e.flags = f;
                    return e;
                end
                case (op)
                    OP_LSL: begin x = {16'd0, a} << n; r = x[15:0]; c = x[16]; end
                    OP_LSR: begin x = {a, 16'd0} >> n; r = x[31:16]; c = x[15]; end
                    OP_ASR: begin x = $signed({a, 16'd0}) >>> n; r = x[31:16]; c = x[15]; end
                    OP_ROL: begin r = (a << n) | (a >> (16 - n)); c = r[0]; end
                    default: begin r = (a >> n) | (a << (16 - n)); c = r[15]; end
                endcase
                e.lat = n;
            end
            OP_MUL: begin
                x = {16'd0, a} * {16'd0, b};
                r = x[15:0];
                c = |x[31:16];
                e.lat = 16;
            end
            default: r = a;
        endcase
        if (op != OP_CMP) e.out = r;
        e.flags = {v, r[15], c, (r == 16'd0)};
        return e;
    endfunction

    task automatic wait_result(input bit intrude);
        exp_t e;
        int   busy_n;
        bit   got;
        busy_n = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (intrude && i == 3) begin
                start = 1'b1; oper = OP_ADD; a_in = 16'h1111; b_in = 16'h2222;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                if (sb_q.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("out", {16'd0, out}, {16'd0, e.out});
                    check_val("flags", {28'd0, proc_flags_out}, {28'd0, e.flags});
                    check_val("done_cycle", cyc, e.acc + e.lat);
                    check_val("busy_cycles", busy_n, e.lat);
                    check_val("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end else if (busy) begin
                busy_n++;
            end
        end
        if (!got) check_val("timeout", 32'd0, 32'd1);
        @(negedge clk);
        check_val("done_pulse", {31'd0, done}, 32'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input bit intrude);
        exp_t e;
        @(negedge clk);
        e = model(op, a, b, f, model_out);
        e.acc = cyc + 1;
        model_out = e.out;
        sb_q.push_back(e);
        start = 1'b1; oper = op; a_in = a; b_in = b; proc_flags_in = f;
        @(posedge clk);
        #1 start = 1'b0;
        wait_result(intrude);
    endtask

    initial begin
        int dones;
        logic [3:0] rop;
        #1 reset = 1'b1;
        #2;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_out", {16'd0, out}, 32'd0);
        check_val("rst_flags", {28'd0, proc_flags_out}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run_op(OP_ADD, 16'hFFFF, 16'h0001, 4'b0000, 1'b0);
        run_op(OP_SBC, 16'h0005, 16'h0003, 4'b0000, 1'b0);
        run_op(OP_CMP, 16'h0003, 16'h0005, 4'b0000, 1'b0);
        run_op(OP_ADC, 16'h7FFF, 16'h0000, 4'b0010, 1'b0);
        run_op(OP_SUB, 16'h8000, 16'h0001, 4'b0000, 1'b0);
        run_op(OP_AND, 16'hF0F0, 16'h0FF0, 4'b1010, 1'b0);
        run_op(OP_ORR, 16'h0000, 16'h0000, 4'b0110, 1'b0);
        run_op(OP_XOR, 16'hAAAA, 16'h5555, 4'b0000, 1'b0);
        run_op(OP_CPY, 16'h1234, 16'hFFFF, 4'b1010, 1'b0);
        run_op(4'd15,  16'h8765, 16'h0001, 4'b0010, 1'b0);
        run_op(OP_LSR, 16'h8001, 16'd20,   4'b0000, 1'b0);
        run_op(OP_LSL, 16'h8001, 16'd0,    4'b1010, 1'b0);
        run_op(OP_ROR, 16'h0001, 16'd17,   4'b0000, 1'b0);
        run_op(OP_ASR, 16'h8000, 16'd3,    4'b1000, 1'b0);
        run_op(OP_ROL, 16'h8001, 16'd1,    4'b0000, 1'b0);
        run_op(OP_LSL, 16'h00F0, 16'd4,    4'b0000, 1'b0);
        run_op(OP_ROL, 16'h1234, 16'd16,   4'b0101, 1'b0);
        run_op(OP_MUL, 16'h0100, 16'h0100, 4'b0000, 1'b1);
        run_op(OP_MUL, 16'h1234, 16'h0003, 4'b1000, 1'b0);

        // Randomised sequence
        for (int k = 0; k < 24; k++) begin
            rop = 4'($urandom_range(0, 15));
            run_op(rop, 16'($urandom),
                   is_shift_op(rop) ? 16'($urandom_range(0, 20)) : 16'($urandom),
                   4'($urandom_range(0, 15)), 1'b0);
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; oper = OP_MUL; a_in = 16'h0003; b_in = 16'h0007; proc_flags_in = 4'd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mul_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_out", {16'd0, out}, 32'd0);
        check_val("abort_flags", {28'd0, proc_flags_out}, 32'd0);
        model_out = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("abort_no_done", dones, 32'd0);
        run_op(OP_ADD, 16'd2, 16'd3, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, data path width in bits (>= 4, power of two).
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the internal step counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new operation; accepted only when busy=0.
REQ-006 oper  input  4  operation code (alu_pkg enum), sampled on acceptance.
REQ-007 a_in, b_in  input  WIDTH each  operands, sampled on acceptance.
REQ-008 proc_flags_in  input  4  incoming flags {V,N,C,Z}, sampled on acceptance.
REQ-009 busy  output  1  high while a multi-cycle operation is executing.
REQ-010 done  output  1  one-cycle pulse when out/proc_flags_out update.
REQ-011 out  output  WIDTH  registered result, held until next completion.
REQ-012 proc_flags_out  output  4  registered flags, held until next completion.

Function
REQ-013 FSM states IDLE, SHIFT, MUL; start in IDLE with busy=0 ignored except on acceptance.
REQ-014 start while busy=1 is ignored; no queueing.
REQ-015 Single-cycle ops (ADD, ADC, SUB, SBC, CMP, AND, ORR, XOR, CPY, zero-count shifts/rotates): accepted at edge t, done=1 and results valid after edge t, FSM stays IDLE.
REQ-016 ADD: a+b; ADC: a+b+Cin; SUB: a+~b+1; SBC: a+~b+Cin; C = bit WIDTH of the WIDTH+1 sum; V = signed overflow.
REQ-017 CMP: flags as SUB; out retains its previous value.
REQ-018 AND/ORR/XOR/CPY(out=a): C and V copied from proc_flags_in.
REQ-019 LSL/LSR/ASR: count n = min(b_in, WIDTH); ROL/ROR: n = b_in mod WIDTH.
REQ-020 Shift/rotate with n=0: out=a_in, all four flags copied from proc_flags_in, single cycle.
REQ-021 Shift/rotate with n>0: enter SHIFT, busy=1, one bit position per cycle, done after n cycles in SHIFT (latency n+1 edges from acceptance), return to IDLE.
REQ-022 Shift C = last bit shifted out (LSL: old MSB; LSR/ASR: old LSB); rotate C = last bit carried across the boundary; V copied in.
REQ-023 MUL: unsigned shift-add, enter MUL, busy=1 for exactly WIDTH cycles, done on last; out = low WIDTH bits; C=1 iff high WIDTH bits nonzero; V copied in.
REQ-024 Undefined opcodes behave as CPY.
REQ-025 For every completing op except CMP and zero-count shifts: Z = (out==0), N = out[WIDTH-1]; CMP uses the discarded difference for Z and N.
REQ-026 busy falls and done rises on the same edge; a new start may be accepted in the cycle after done.

Reset
REQ-027 reset asserted: FSM->IDLE, busy=0, done=0, out=0, proc_flags_out=0, counter=0, immediately and independent of clk.
REQ-028 reset mid-SHIFT/MUL aborts the operation; no done pulse issued for it.

Structure
REQ-029 Package alu_pkg holds the oper enum (ADD..ROR, CPY, MUL), flag bit indices (Z=0, C=1, N=2, V=3) and flag-vector width.
REQ-030 One sub-module alu_seq_core: combinational single-cycle arithmetic/logic and one-bit shift/rotate step; FSM, counter and registers stay in alu_seq.

Verification (WIDTH=16)
REQ-031 ADD a=0xFFFF b=0x0001 -> done at t+1, out=0x0000, Z=1, C=1, V=0, N=0.
REQ-032 SBC a=0x0005 b=0x0003 Cin=0 -> out=0x0001, C=1; CMP a=0x0003 b=0x0005 -> out unchanged, C=0, N=1.
REQ-033 LSR a=0x8001 b=20 -> n=16, busy 16 cycles, out=0x0000, C=1, Z=1; LSL a=0x8001 b=0 -> out=0x8001, flags = proc_flags_in.
REQ-034 ROR a=0x0001 b=17 -> n=1, done at t+2, out=0x8000, C=1, N=1.
REQ-035 MUL a=0x0100 b=0x0100 -> busy 16 cycles, out=0x0000, C=1, Z=1; second start during busy ignored.
REQ-036 reset asserted mid-MUL -> busy=0, out=0, flags=0, no done pulse; next ADD 2+3 -> out=0x0005.
